seven_seg_scanner: RTL and testbench

Time-multiplexed driver for the Basys3 4-digit common-anode seven-segment display, sitting directly downstream of the BCD digit counter. It takes the four BCD digits produced in the divided-clock domain and synchronises them into the board-clock domain. It then scans one digit per refresh slot and drives active-low anodes, segments and decimal point. Leading-zero blanking and invalid-BCD indication are built in.

---
 rtl/seven_seg_pkg.sv | 42 ++++
 rtl/seven_seg_scanner_bcd_to_seg.sv | 31 +++
 rtl/seven_seg_scanner.sv | 148 ++++++++++++++
 tb/tb_seven_seg_scanner.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
//
// Shared types and constants for the Basys3 seven-segment scanner.
//   seg_t       : 7-bit active-low segment vector, bit 0 = a ... bit 6 = g
//   SEG_DIGIT   : glyphs for decimal digits 0-9
//   SEG_DASH    : glyph shown for codes 10-15 (segment g only)
//   SEG_BLANK   : all segments dark
//   NUM_DIGITS  : number of digit positions on the display
//   SCAN_WIDTH  : width of the digit scan index
// ---------------------------------------------------------------------------
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SCAN_WIDTH = $clog2(NUM_DIGITS);

    typedef logic [6:0]            seg_t;
    typedef logic [SCAN_WIDTH-1:0] scan_idx_t;

    // Active-low patterns, written g..a (MSB = g).
    localparam seg_t SEG_DIGIT [0:9] = '{
        7'b1000000,   // 0
        7'b1111001,   // 1
        7'b0100100,   // 2
        7'b0110000,   // 3
        7'b0011001,   // 4
        7'b0010010,   // 5
        7'b0000010,   // 6
        7'b1111000,   // 7
        7'b0000000,   // 8
        7'b0010000    // 9
    };

    localparam seg_t SEG_DASH  = 7'b0111111;
    localparam seg_t SEG_BLANK = 7'b1111111;

    // One-hot-low anode vector for a given scan position.
    function automatic logic [NUM_DIGITS-1:0] anode_for(input scan_idx_t idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/seven_seg_scanner_bcd_to_seg.sv
// ---------------------------------------------------------------------------
// bcd_to_seg
//
// Purely combinational BCD to seven-segment decoder (active-low outputs).
// Codes 0-9 produce the normal digit glyphs; any other code produces a dash
// so that a corrupted or out-of-range digit is visible on the display.
//
// Ports:
//   bcd  in  DIGIT_WIDTH  BCD digit
//   seg  out 7            active-low segments, bit 0 = a ... bit 6 = g
// ---------------------------------------------------------------------------
module bcd_to_seg
    import seven_seg_pkg::*;
#(
    parameter int DIGIT_WIDTH = 4
) (
    input  logic [DIGIT_WIDTH-1:0] bcd,
    output seg_t                   seg
);

    // Default to the dash so every code outside 0-9 is flagged as invalid.
    always_comb begin
        seg = SEG_DASH;
        for (int i = 0; i < 10; i++) begin
            if (bcd == DIGIT_WIDTH'(i)) begin
                seg = SEG_DIGIT[i];
            end
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
//
// Time-multiplexed driver for the Basys3 4-digit common-anode display.
// The four BCD digits arrive from the divided-clock domain and are brought
// into the board-clock domain through a three-stage synchroniser; a held
// copy is only updated when two consecutive synchronised samples agree, so
// a bus caught mid-transition never reaches the display. One digit is lit
// per refresh slot, with optional leading-zero blanking.
//
// Parameters:
//   DIGIT_WIDTH          width of each BCD digit
//   REFRESH_COUNT        clock cycles per digit slot (>= 2)
//   BLANK_LEADING_ZEROS  1 = blank leading zeros on the upper three digits
//
// Ports:
//   clock            in  1            board clock
//   reset            in  1            asynchronous, active-high reset
//   digit_ones       in  DIGIT_WIDTH  BCD ones (foreign clock domain)
//   digit_tens       in  DIGIT_WIDTH  BCD tens
//   digit_hundreds   in  DIGIT_WIDTH  BCD hundreds
//   digit_thousands  in  DIGIT_WIDTH  BCD thousands
//   dp_enable        in  4            decimal point per digit, bit 0 = ones
//   anode            out 4            active-low digit enables, bit 0 = ones
//   segment          out 7            active-low segments, bit 0 = a
//   dp               out 1            active-low decimal point
// ---------------------------------------------------------------------------
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIGIT_WIDTH         = 4,
    parameter int REFRESH_COUNT       = 100_000,
    parameter int BLANK_LEADING_ZEROS = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DIGIT_WIDTH-1:0] digit_ones,
    input  logic [DIGIT_WIDTH-1:0] digit_tens,
    input  logic [DIGIT_WIDTH-1:0] digit_hundreds,
    input  logic [DIGIT_WIDTH-1:0] digit_thousands,
    input  logic [NUM_DIGITS-1:0]  dp_enable,
    output logic [NUM_DIGITS-1:0]  anode,
    output seg_t                   segment,
    output logic                   dp
);

    localparam int BUS_WIDTH = NUM_DIGITS * DIGIT_WIDTH;
    localparam int CNT_WIDTH = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(REFRESH_COUNT - 1);

    logic [BUS_WIDTH-1:0]   digit_bus;
    logic [BUS_WIDTH-1:0]   sync_s1;
    logic [BUS_WIDTH-1:0]   sync_s2;
    logic [BUS_WIDTH-1:0]   sync_s3;
    logic [BUS_WIDTH-1:0]   held;

    logic [CNT_WIDTH-1:0]   refresh_count;
    scan_idx_t              scan_idx;

    logic [DIGIT_WIDTH-1:0] held_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]  digit_is_zero;
    logic [DIGIT_WIDTH-1:0] current_digit;
    seg_t                   decoded_seg;
    logic                   blank_current;

    // Index 0 sits in the low bits so it lines up with scan_idx 0 = ones.
    assign digit_bus = {digit_thousands, digit_hundreds, digit_tens, digit_ones};

    // Synchroniser chain plus compare-load. s2 and s3 are consecutive
    // samples of the foreign bus; when they differ the source was caught
    // mid-update (possibly with bits skewed), so the held copy is left alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
            sync_s3 <= '0;
            held    <= '0;
        end else begin
            sync_s1 <= digit_bus;
            sync_s2 <= sync_s1;
            sync_s3 <= sync_s2;
            if (sync_s2 == sync_s3) begin
                held <= sync_s2;
            end
        end
    end

    // Slot timer: every REFRESH_COUNT cycles the scan moves to the next digit.
    // scan_idx wraps naturally from the last digit back to ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            refresh_count <= '0;
            scan_idx      <= '0;
        end else if (refresh_count == CNT_LAST) begin
            refresh_count <= '0;
            scan_idx      <= scan_idx + scan_idx_t'(1);
        end else begin
            refresh_count <= refresh_count + CNT_WIDTH'(1);
        end
    end

    // Split the held bus back into digits and flag the zero ones.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            held_digit[i]    = held[i*DIGIT_WIDTH +: DIGIT_WIDTH];
            digit_is_zero[i] = (held[i*DIGIT_WIDTH +: DIGIT_WIDTH] == '0);
        end
    end

    assign current_digit = held_digit[scan_idx];

    bcd_to_seg #(
        .DIGIT_WIDTH (DIGIT_WIDTH)
    ) u_decoder (
        .bcd (current_digit),
        .seg (decoded_seg)
    );

    // A digit is a leading zero when it and every digit above it are zero.
    // Invalid codes are nonzero, so they stop the blanking and show a dash.
    always_comb begin
        blank_current = 1'b0;
        if (BLANK_LEADING_ZEROS != 0) begin
            case (scan_idx)
                2'd3:    blank_current = digit_is_zero[3];
                2'd2:    blank_current = digit_is_zero[3] & digit_is_zero[2];
                2'd1:    blank_current = digit_is_zero[3] & digit_is_zero[2]
                                         & digit_is_zero[1];
                default: blank_current = 1'b0;
            endcase
        end
    end

    // Registered outputs. A blanked digit keeps its anode and decimal point
    // so a lone dp (e.g. "  .0") can still be shown in a blank position.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            anode   <= '1;
            segment <= SEG_BLANK;
            dp      <= 1'b1;
        end else begin
            anode   <= anode_for(scan_idx);
            segment <= blank_current ? SEG_BLANK : decoded_seg;
            dp      <= ~dp_enable[scan_idx];
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scanner
//
// Self-checking bench for seven_seg_scanner with REFRESH_COUNT = 4.
// The stimulus process drives one input set per clock and pushes the
// predicted output for that edge into a queue; a monitor pops and compares
// on every falling edge. The prediction works from the external behaviour:
// which digit is on screen follows from the edge number, and the digit
// value is the latest input sample seen on two consecutive edges.
// ---------------------------------------------------------------------------
module tb_seven_seg_scanner;

    localparam int RC = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] digit_ones;
    logic [3:0] digit_tens;
    logic [3:0] digit_hundreds;
    logic [3:0] digit_thousands;
    logic [3:0] dp_enable;
    logic [3:0] anode;
    logic [6:0] segment;
    logic       dp;

    typedef struct {
        logic [3:0] anode;
        logic [6:0] segment;
        logic       dp;
        int         edgeNum;
    } expect_t;

    expect_t     expQ[$];
    logic [15:0] sampBus[$];
    int          edgeCount = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    seven_seg_scanner #(
        .DIGIT_WIDTH         (4),
        .REFRESH_COUNT       (RC),
        .BLANK_LEADING_ZEROS (1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .digit_ones      (digit_ones),
        .digit_tens      (digit_tens),
        .digit_hundreds  (digit_hundreds),
        .digit_thousands (digit_thousands),
        .dp_enable       (dp_enable),
        .anode           (anode),
        .segment         (segment),
        .dp              (dp)
    );

    // Bus value sampled at edge k since reset release; zero before edge 1.
    function automatic logic [15:0] inAt(int k);
        if (k <= 0) return 16'h0000;
        return sampBus[k-1];
    endfunction

    // Displayed value after edge m: the newest sample that was seen on two
    // consecutive edges, visible two edges after the second of them.
    function automatic logic [15:0] heldAfter(int m);
        for (int j = m; j >= 3; j--) begin
            if (inAt(j-2) == inAt(j-3)) return inAt(j-2);
        end
        return 16'h0000;
    endfunction

    // Lit segments in common-cathode style (1 = on), g..a.
    function automatic logic [6:0] litPattern(logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic expect_t predict(int n, logic [3:0] dpe);
        expect_t     e;
        logic [3:0]  anodeTable [4];
        logic [3:0]  d [4];
        logic [15:0] h;
        int          idx;
        int          lead;
        anodeTable[0] = 4'b1110;
        anodeTable[1] = 4'b1101;
        anodeTable[2] = 4'b1011;
        anodeTable[3] = 4'b0111;
        idx = ((n - 1) / RC) % 4;
        h = heldAfter(n - 1);
        for (int i = 0; i < 4; i++) d[i] = h[i*4 +: 4];
        lead = 0;
        for (int p = 1; p < 4; p++) begin
            if (d[p] != 4'd0) lead = p;
        end
        e.anode   = anodeTable[idx];
        e.segment = (idx > lead) ? 7'b1111111 : ~litPattern(d[idx]);
        e.dp      = ~dpe[idx];
        e.edgeNum = n;
        return e;
    endfunction

    task automatic checkOutput(string name, logic [11:0] act, logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got anode=%b seg=%b dp=%b, required anode=%b seg=%b dp=%b",
                     name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic applyStimulus(logic [15:0] bus, logic [3:0] dpe);
        expect_t e;
        {digit_thousands, digit_hundreds, digit_tens, digit_ones} = bus;
        dp_enable = dpe;
        @(posedge clock);
        #1;
        edgeCount++;
        sampBus.push_back(bus);
        e = predict(edgeCount, dpe);
        expQ.push_back(e);
        @(negedge clock);
    endtask

    task automatic holdStimulus(logic [15:0] bus, logic [3:0] dpe, int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(bus, dpe);
    endtask

    // Asserts reset away from any clock edge and checks the outputs clear
    // immediately, then releases it on a falling edge.
    task automatic doReset(string name);
        #2;
        reset = 1'b1;
        #1;
        checkOutput(name, {anode, segment, dp}, 12'b1111_1111111_1);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        edgeCount = 0;
        sampBus.delete();
    endtask

    function automatic logic [15:0] randomBus();
        logic [15:0] b;
        for (int i = 0; i < 4; i++) begin
            b[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        end
        return b;
    endfunction

    // Monitor: one comparison per predicted edge.
    initial begin
        expect_t e;
        forever begin
            @(negedge clock);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput($sformatf("edge%0d", e.edgeNum), {anode, segment, dp},
                            {e.anode, e.segment, e.dp});
            end
        end
    end

    initial begin
        logic [15:0] valA;
        logic [15:0] valB;
        int guard;
        reset = 1'b1;
        {digit_thousands, digit_hundreds, digit_tens, digit_ones} = 16'h0000;
        dp_enable = 4'b0000;
        repeat (3) @(negedge clock);
        checkOutput("reset_state", {anode, segment, dp}, 12'b1111_1111111_1);
        reset = 1'b0;
        edgeCount = 0;
        sampBus.delete();

        $display("[TB] digits 1881 with dp on hundreds");
        holdStimulus(16'h1881, 4'b0100, 28);

        $display("[TB] digits 0007 leading-zero blanking");
        holdStimulus(16'h0007, 4'b0000, 24);

        $display("[TB] invalid tens code");
        holdStimulus(16'h00C3, 4'b0001, 24);

        $display("[TB] bus toggling every cycle");
        valA = randomBus();
        valB = valA ^ 16'h5A5A;
        for (int i = 0; i < 40; i++) applyStimulus((i % 2 == 0) ? valA : valB, 4'b1000);
        holdStimulus(16'h2468, 4'b1000, 24);

        $display("[TB] randomized holds");
        for (int r = 0; r < 30; r++) begin
            holdStimulus(randomBus(), 4'($urandom_range(0, 15)), $urandom_range(1, 12));
        end
        for (int r = 0; r < 20; r++) applyStimulus(randomBus(), 4'($urandom_range(0, 15)));
        holdStimulus(16'h0905, 4'b0010, 20);

        $display("[TB] reset during tens slot");
        while (edgeCount < 1 || ((edgeCount - 1) / RC) % 4 != 1) begin
            applyStimulus(16'h4321, 4'b0000);
        end
        doReset("reset_mid_scan");
        holdStimulus(16'h4321, 4'b1111, 20);

        #1;
        guard = 0;
        while (expQ.size() > 0 && guard < 20) begin
            @(negedge clock);
            #1;
            guard++;
        end
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
